// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling/ReLU/requantisation stage that follows
// the 1-D convolution engine.
//   - Row geometry and widths (N_IN, IN_W, OUT_W, SHIFT and derived values)
//   - FSM state type
//   - relu_requant(): ReLU, arithmetic right shift, saturate to OUT_W bits
// ---------------------------------------------------------------------------
package pool_pkg;

    localparam int unsigned N_IN    = 30;
    localparam int unsigned IN_W    = 18;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned SHIFT   = 2;
    localparam int unsigned N_OUT   = N_IN / 2;
    localparam int unsigned IDX_W   = $clog2(N_OUT);
    localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StDone
    } state_e;

    // Negative values clamp to zero, so the shift only ever sees a
    // non-negative value and a logical shift equals the arithmetic one.
    function automatic logic [OUT_W-1:0] relu_requant(input logic signed [IN_W-1:0] m);
        logic [IN_W-1:0] r;
        logic [IN_W-1:0] s;
        if (m[IN_W-1]) begin
            r = '0;
        end else begin
            r = $unsigned(m);
        end
        s = r >> SHIFT;
        if (s > IN_W'(OUT_MAX)) begin
            return OUT_W'(OUT_MAX);
        end
        return s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/pool_relu_unit_if.sv
// ---------------------------------------------------------------------------
// pool_relu_unit_if
// Bundles the row-capture input, the status flags and the pooled-byte
// valid/ready stream of pool_relu_unit.
//   master : conv engine + downstream consumer side (drives in_*, out_ready)
//   slave  : pool_relu_unit side (drives status and out_* stream)
// ---------------------------------------------------------------------------
interface pool_relu_unit_if;
    import pool_pkg::*;

    logic                   in_valid;
    logic signed [IN_W-1:0] in_data [N_IN];
    logic                   busy;
    logic                   drop_err;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;
    logic [IDX_W-1:0]       out_index;
    logic                   out_last;
    logic                   done;

    modport master (
        output in_valid, in_data, out_ready,
        input  busy, drop_err, out_valid, out_data, out_index, out_last, done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output busy, drop_err, out_valid, out_data, out_index, out_last, done
    );

endinterface

// File: rtl/pool_pair.sv
// ---------------------------------------------------------------------------
// pool_pair
// Combinational 2:1 max-pool of one input pair followed by ReLU, shift and
// saturation to one output byte.
//   i_a, i_b : signed IN_W-bit conv results
//   o_byte   : requantised OUT_W-bit result
// ---------------------------------------------------------------------------
module pool_pair
    import pool_pkg::*;
(
    input  logic signed [IN_W-1:0] i_a,
    input  logic signed [IN_W-1:0] i_b,
    output logic [OUT_W-1:0]       o_byte
);

    logic signed [IN_W-1:0] w_max;

    assign w_max  = (i_a > i_b) ? i_a : i_b;
    assign o_byte = relu_requant(w_max);

endmodule

// File: rtl/pool_relu_unit.sv
// ---------------------------------------------------------------------------
// pool_relu_unit
// Captures one row of N_IN signed conv results on an in_valid pulse and
// streams N_OUT pooled, ReLU'd, requantised bytes over valid/ready, then
// pulses done for one cycle.
//   clk, rst : clock and synchronous active-high reset
//   io_bus   : slave side of pool_relu_unit_if (capture, status, stream)
// ---------------------------------------------------------------------------
module pool_relu_unit
    import pool_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    pool_relu_unit_if.slave  io_bus
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_OUT - 1);

    state_e                 r_state;
    state_e                 w_state_d;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_d;
    logic [IDX_W-1:0]       w_nidx;
    logic [IDX_W:0]         w_base;
    logic signed [IN_W-1:0] r_buf [N_IN];
    logic [OUT_W-1:0]       r_out_data;
    logic                   r_out_last;
    logic                   r_drop_err;
    logic                   w_capture;
    logic                   w_load_out;
    logic signed [IN_W-1:0] w_a;
    logic signed [IN_W-1:0] w_b;
    logic [OUT_W-1:0]       w_byte;

    assign w_nidx = r_idx + IDX_W'(1);
    assign w_base = {w_nidx, 1'b0};

    // The output byte is registered, so the pair feeding it is always the one
    // for the *next* index: straight from in_data on capture (the buffer is
    // not loaded yet), otherwise from the buffer at idx+1.
    always_comb begin
        w_state_d  = r_state;
        w_idx_d    = r_idx;
        w_capture  = 1'b0;
        w_load_out = 1'b0;
        w_a        = io_bus.in_data[0];
        w_b        = io_bus.in_data[1];
        unique case (r_state)
            StIdle: begin
                if (io_bus.in_valid) begin
                    w_capture  = 1'b1;
                    w_load_out = 1'b1;
                    w_idx_d    = '0;
                    w_state_d  = StEmit;
                end
            end
            StEmit: begin
                if (io_bus.out_ready) begin
                    if (r_idx == LastIdx) begin
                        w_state_d = StDone;
                    end else begin
                        w_idx_d    = w_nidx;
                        w_load_out = 1'b1;
                        w_a        = r_buf[w_base];
                        w_b        = r_buf[{w_nidx, 1'b1}];
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
        end
    end

    pool_pair u_pool_pair (
        .i_a    (w_a),
        .i_b    (w_b),
        .o_byte (w_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= '{default: '0};
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_buf <= io_bus.in_data;
            end
            if (w_load_out) begin
                r_out_data <= w_byte;
                r_out_last <= (w_idx_d == LastIdx);
            end
            if (io_bus.in_valid && (r_state != StIdle)) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign io_bus.busy      = (r_state != StIdle);
    assign io_bus.out_valid = (r_state == StEmit);
    assign io_bus.done      = (r_state == StDone);
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_index = r_idx;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.drop_err  = r_drop_err;

endmodule

// File: tb/tb_pool_relu_unit.sv
// ---------------------------------------------------------------------------
// tb_pool_relu_unit
// Self-checking bench for pool_relu_unit: a queue-based reference model of
// the pooled byte stream, checked every cycle, plus literal expectations for
// the directed rows.
// ---------------------------------------------------------------------------
module tb_pool_relu_unit;
    import pool_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_relu_unit_if u_if ();

    pool_relu_unit dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_cap = 0;
    int done_cyc = -1;
    int ready_mode = 0;

    int m_q[$];
    bit m_done_due = 1'b0;
    bit m_drop = 1'b0;
    bit m_after_rst = 1'b1;
    int got[$];

    bit busy_e;
    bit nd;
    int idx_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec arithmetic in plain integers: max, clamp at 0, divide by 2^SHIFT, cap.
    function automatic int ref_byte(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 0) m = 0;
        m = m / (1 << SHIFT);
        if (m > 255) m = 255;
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: checks at negedge, then advances the model to the
    // state expected after the coming posedge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            busy_e = (m_q.size() > 0) || m_done_due;
            chk("out_valid", u_if.out_valid, m_q.size() > 0);
            chk("busy", u_if.busy, busy_e);
            chk("done", u_if.done, m_done_due);
            chk("drop_err", u_if.drop_err, m_drop);
            if (m_after_rst) begin
                chk("rst_out_data", u_if.out_data, 0);
                chk("rst_out_index", u_if.out_index, 0);
                chk("rst_out_last", u_if.out_last, 0);
                m_after_rst = 1'b0;
            end
            if (m_q.size() > 0) begin
                idx_e = N_OUT - m_q.size();
                chk("out_data", u_if.out_data, m_q[0]);
                chk("out_index", u_if.out_index, idx_e);
                chk("out_last", u_if.out_last, idx_e == N_OUT - 1);
            end
            if (u_if.done === 1'b1) done_cyc = cyc;

            if (rst) begin
                m_q.delete();
                m_done_due  = 1'b0;
                m_drop      = 1'b0;
                m_after_rst = 1'b1;
            end else begin
                nd = 1'b0;
                if (m_q.size() > 0 && u_if.out_ready) begin
                    got.push_back(int'(u_if.out_data));
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) nd = 1'b1;
                end
                if (u_if.in_valid) begin
                    if (busy_e) begin
                        m_drop = 1'b1;
                    end else begin
                        for (int k = 0; k < N_OUT; k++) begin
                            m_q.push_back(ref_byte(int'(u_if.in_data[2*k]),
                                                   int'(u_if.in_data[2*k+1])));
                        end
                        t_cap = cyc;
                    end
                end
                m_done_due = nd;
            end
        end
    end

    // out_ready driver: held high or pseudo-random.
    initial begin
        u_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_if.out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_row(input logic signed [IN_W-1:0] r [N_IN]);
        u_if.in_data  = r;
        u_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_q.size() > 0 || m_done_due || u_if.busy !== 1'b0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", n < 400, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_got(input string name, input int lit [N_OUT]);
        chk({name, "_count"}, got.size(), N_OUT);
        for (int k = 0; k < N_OUT; k++) begin
            if (k < got.size()) chk(name, got[k], lit[k]);
        end
    endtask

    initial begin
        logic signed [IN_W-1:0] row [N_IN];
        logic signed [IN_W-1:0] row2 [N_IN];
        int lit_basic [N_OUT];
        int lit_zero [N_OUT];
        int lit_full [N_OUT];
        int n;

        lit_basic = '{2, 0, 255, 254, 255, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        lit_zero  = '{default: 0};
        lit_full  = '{default: 255};

        u_if.in_valid = 1'b0;
        u_if.in_data  = '{default: '0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic row, out_ready held high.
        row = '{default: '0};
        row[0] = -4;    row[1] = 8;
        row[2] = -10;   row[3] = -3;
        row[4] = 2000;  row[5] = 5;
        row[6] = 1019;  row[7] = 0;
        row[8] = 1020;  row[9] = 1;
        ready_mode = 0;
        got.delete();
        send_row(row);
        wait_idle();
        chk_got("basic", lit_basic);
        chk("done_latency", done_cyc - t_cap, 16);

        // Backpressure on the same row.
        ready_mode = 1;
        got.delete();
        send_row(row);
        wait_idle();
        chk_got("backpressure", lit_basic);

        // Negative and positive full scale.
        row2 = '{default: -18'sd131072};
        got.delete();
        send_row(row2);
        wait_idle();
        chk_got("neg_full", lit_zero);

        row2 = '{default: 18'sd131071};
        got.delete();
        send_row(row2);
        wait_idle();
        chk_got("pos_full", lit_full);

        // Overlap: drop at T+5, accept at T+17.
        ready_mode = 0;
        got.delete();
        send_row(row);
        repeat (4) @(posedge clk);
        #1;
        row2 = '{default: 18'sd1000};
        send_row(row2);
        repeat (11) @(posedge clk);
        #1;
        send_row(row2);
        wait_idle();
        chk("overlap_drop_err", u_if.drop_err, 1);
        chk("overlap_count", got.size(), 2 * N_OUT);
        for (int k = 0; k < N_OUT && k < got.size(); k++) begin
            chk("overlap_first", got[k], lit_basic[k]);
        end
        for (int k = N_OUT; k < got.size(); k++) begin
            chk("overlap_third", got[k], 250);
        end

        // in_valid during the done cycle is dropped.
        send_row(row);
        n = 0;
        while (u_if.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", n < 100, 1);
        send_row(row2);
        wait_idle();

        // Reset while index 7 is presented.
        got.delete();
        send_row(row);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_index", u_if.out_index, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cyc = -1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cyc, -1);
        got.delete();
        send_row(row);
        wait_idle();
        chk_got("after_rst", lit_basic);

        // Randomised rows with random backpressure and stray in_valid pulses.
        for (int r = 0; r < 8; r++) begin
            ready_mode = r % 2 == 0 ? 1 : 0;
            for (int i = 0; i < N_IN; i++) begin
                if ($urandom_range(0, 1) == 1) row[i] = IN_W'($urandom);
                else row[i] = IN_W'($signed($urandom_range(0, 2400)) - 1200);
            end
            send_row(row);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 24)) @(posedge clk);
                #1;
                send_row(row2);
            end
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
